// File: rtl/hud_pkg.sv
// hud_pkg: constants, glyph indices and the converter state type shared by the HUD text engine.
package hud_pkg;
    localparam int GLYPH_W = 30;
    localparam int GLYPH_H = 45;
    localparam logic [3:0] DIGIT0 = 4'd0, DIGIT1 = 4'd1, DIGIT2 = 4'd2, DIGIT3 = 4'd3, DIGIT4 = 4'd4;
    localparam logic [3:0] DIGIT5 = 4'd5, DIGIT6 = 4'd6, DIGIT7 = 4'd7, DIGIT8 = 4'd8, DIGIT9 = 4'd9;
    localparam logic [3:0] HEART = 4'd10, HALF_HEART = 4'd11, BLANK = 4'd12;
    localparam logic [3:0] SHIFT_LAST = 4'd13;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} bcd_state_t;
endpackage

// File: rtl/bcd_converter.sv
// bcd_converter: 14-bit binary to 4-digit BCD via double-dabble, one shift per cycle.
// Ports: Clk/Reset_n clock and async active-low reset; i_start accepted only while idle;
// i_bin value to convert; o_busy high in SHIFT and DONE; o_done high in DONE; o_bcd result, valid in DONE.
module bcd_converter (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        i_start,
    input  logic [13:0] i_bin,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_bcd
);
    import hud_pkg::*;
    bcd_state_t r_state, w_next;
    logic [3:0]  r_cnt;
    logic [13:0] r_bin;
    logic [15:0] r_bcd, w_adj;
    genvar n;
    // Add-3 to any digit >= 5 so the following left shift carries correctly into the next digit.
    for (n = 0; n < 4; n++) begin : g_adj
        assign w_adj[4*n +: 4] = (r_bcd[4*n +: 4] >= 4'd5) ? r_bcd[4*n +: 4] + 4'd3 : r_bcd[4*n +: 4];
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = i_start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_next = (r_cnt == SHIFT_LAST) ? ST_DONE : ST_SHIFT;
            default:  w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && i_start) begin
                r_bin <= i_bin;
                r_bcd <= '0;
                r_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                {r_bcd, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end
    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_DONE);
    assign o_bcd  = r_bcd;
endmodule

// File: rtl/hud_text_engine.sv
// hud_text_engine: renders a 4-digit score and 5 heart cells from a glyph ROM.
// Ports: Clk/Reset_n clock and async active-low reset; DrawX/DrawY current pixel;
// frame_start latches score/health when idle; char_data_out ROM palette data (1-cycle latency);
// char_idx/char_read_address ROM request; text_on/text_color pixel output; bcd_busy conversion active.
module hud_text_engine #(
    parameter int GLYPH_W = hud_pkg::GLYPH_W,
    parameter int GLYPH_H = hud_pkg::GLYPH_H,
    parameter int SCORE_X = 16,
    parameter int SCORE_Y = 8,
    parameter int HEART_X = 464,
    parameter int HEART_Y = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic [15:0] score,
    input  logic [3:0]  health,
    input  logic [4:0]  char_data_out,
    output logic [3:0]  char_idx,
    output logic [18:0] char_read_address,
    output logic        text_on,
    output logic [4:0]  text_color,
    output logic        bcd_busy
);
    import hud_pkg::*;
    logic        w_start, w_done, w_hit, r_in;
    logic [13:0] w_score_sat;
    logic [15:0] w_bcd, r_digits;
    logic [3:0]  w_health_sat, r_health_pend, r_health, w_idx;
    logic [18:0] w_x, w_y, w_addr;
    assign w_start      = frame_start && !bcd_busy;
    assign w_score_sat  = (score > 16'd9999) ? 14'd9999 : score[13:0];
    assign w_health_sat = (health > 4'd10) ? 4'd10 : health;
    bcd_converter u_bcd (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_start (w_start),
        .i_bin   (w_score_sat),
        .o_busy  (bcd_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );
    // Health is held aside until DONE so digits and hearts change on the same edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_health_pend <= '0;
            r_health      <= '0;
            r_digits      <= '0;
            r_in          <= 1'b0;
        end else begin
            r_in <= w_hit;
            if (w_start) r_health_pend <= w_health_sat;
            if (w_done) begin
                r_digits <= w_bcd;
                r_health <= r_health_pend;
            end
        end
    end
    assign w_x = {9'd0, DrawX};
    assign w_y = {9'd0, DrawY};
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = BLANK;
        w_addr = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_y >= 19'(SCORE_Y) && w_y < 19'(SCORE_Y + GLYPH_H) &&
                w_x >= 19'(SCORE_X + k*GLYPH_W) && w_x < 19'(SCORE_X + (k+1)*GLYPH_W)) begin
                w_hit  = 1'b1;
                w_idx  = r_digits[4*(3-k) +: 4];
                w_addr = (w_y - 19'(SCORE_Y)) * 19'(GLYPH_W) + (w_x - 19'(SCORE_X + k*GLYPH_W));
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (w_y >= 19'(HEART_Y) && w_y < 19'(HEART_Y + GLYPH_H) &&
                w_x >= 19'(HEART_X + i*GLYPH_W) && w_x < 19'(HEART_X + (i+1)*GLYPH_W)) begin
                w_hit  = 1'b1;
                w_idx  = (r_health >= 4'(2*i+2)) ? HEART : (r_health == 4'(2*i+1)) ? HALF_HEART : BLANK;
                w_addr = (w_y - 19'(HEART_Y)) * 19'(GLYPH_W) + (w_x - 19'(HEART_X + i*GLYPH_W));
            end
        end
    end
    assign char_idx          = w_idx;
    assign char_read_address = w_addr;
    assign text_color        = char_data_out;
    assign text_on           = r_in && (char_data_out != 5'd0);
endmodule
